rr_arbiter32: RTL and testbench
===============================

Name: rr_arbiter32

Overview:
- Round-robin arbiter that shares a single 32:1 data-select mux between 32 requesters.
- Produces a registered 5-bit select for the mux, a one-hot grant vector and a valid flag.
- Enforces fairness with a rotating priority pointer and an optional hold-time limit that preempts the current owner.
- Sits between requesting units and the shared 32-way select mux in the datapath.

Parameters:
- NREQ, 32: number of requesters. Fixed at 32; the select width is 5.
- MAX_HOLD, 16: maximum number of cycles an owner may keep the grant while others are waiting. 0 disables preemption.
- CNT_W, 8: width of the hold counter. Must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 32: level requests. req[i] is held high for as long as requester i wants the resource.
- lock, input, 1: while high, suppresses hold-limit preemption of the current owner.
- gnt, output, 32: registered one-hot grant. All zero when idle.
- gnt_valid, output, 1: high while some requester owns the resource.
- sel, output, 5: registered index of the owner. Drives the mux select.
- preempt, output, 1: one-cycle pulse in the cycle after a forced (hold-limit) handover.

Behaviour:
- Reset (asynchronous, any time, including mid-grant):
  - state = IDLE; gnt = 0; gnt_valid = 0; sel = 0; preempt = 0; ptr = 0; hold_cnt = 0.
- Pick function:
  - Returns the first index i with mask[i] = 1, searching ptr, ptr+1, …, 31, 0, …, ptr-1 (wraps 31 to 0).
  - Also returns found = 0 if the mask is empty.
- IDLE state:
  - If any req bit is high at a clock edge, winner = pick(req, ptr).
  - On that same edge: sel <= winner; gnt <= one-hot(winner); gnt_valid <= 1; ptr <= winner+1 (mod 32); hold_cnt <= 0; state <= GRANT.
  - Latency from req to gnt is 1 cycle.
  - If no req is high, all outputs hold. sel keeps its last value so the mux output stays stable.
- GRANT state, evaluated each edge in this priority order:
  1. Release: req[sel] == 0.
     - others = req with bit sel cleared; if pick(others, sel+1) finds a winner, hand over directly to it with no idle bubble (same updates as IDLE, state stays GRANT).
     - Otherwise gnt <= 0, gnt_valid <= 0, state <= IDLE, sel held.
  2. Preempt: MAX_HOLD != 0 and lock == 0 and hold_cnt == MAX_HOLD-1 and others != 0.
     - Hand over to pick(others, sel+1).
     - preempt <= 1 for one cycle.
  3. Otherwise: hold_cnt <= hold_cnt+1, saturating at MAX_HOLD-1. Grant is held.
- Owner alone past the limit: if MAX_HOLD is reached with no other requester, the owner keeps the grant. The counter stays saturated, so preemption fires on the first edge another req appears (with lock low).
- Lock released while saturated: preemption is evaluated on the next edge.
- Preempted owner: if it still holds req high, it re-enters arbitration normally under round-robin order.
- Invariants:
  - gnt is always either zero or one-hot.
  - gnt == one-hot(sel) whenever gnt_valid == 1.
  - gnt_valid == (state == GRANT).
  - preempt is 0 in all cycles other than the one following a forced handover.
- X on req is not tolerated. The bench asserts known values on req outside reset.

Decomposition:
- Package arb_pkg:
  - NREQ = 32, IDX_W = 5.
  - State enum typedef: IDLE, GRANT.
  - Typedef idx_t: IDX_W-bit logic.
- Sub-module rr_pick32:
  - Combinational rotating priority picker.
  - Inputs: 32-bit mask, 5-bit start. Outputs: 5-bit idx, found.
  - Instantiated once. The release path and the preempt path share it via a muxed start/mask: start is always sel+1 and the mask is others in GRANT; start is ptr and the mask is req in IDLE.
- FSM, hold counter and pointer live in rr_arbiter32.

Test Plan:
- Assert rst mid-cycle while gnt_valid = 1 -> gnt, gnt_valid, sel, preempt go to 0 immediately (asynchronous), with no clock edge needed.
- Single request: from reset, req = 0x0000_0010 -> one cycle later sel = 4, gnt = 0x10, gnt_valid = 1. Drop req -> next cycle gnt = 0, gnt_valid = 0, sel stays 4.
- Round-robin wrap: ptr = 31 via a prior grant to 30; req = 0x8000_0001 -> grant 31; release -> direct handover to 0 with no idle cycle between.
- Back-to-back fairness: req = 0x0000_000F held, each owner releases after 1 cycle -> grant order 0, 1, 2, 3, 0, …, with gnt_valid continuously 1.
- Preemption: MAX_HOLD = 4, req[2] held, req[5] rises at the second cycle of grant -> at the 4th grant cycle, handover to 5 and preempt pulses once. With lock = 1 -> no handover until req[2] drops.
- Lone owner: MAX_HOLD = 4, only req[7] held for 10 cycles -> grant is held throughout and preempt stays 0. req[9] then rises -> handover to 9 on the next edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 32-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NREQ  = 32;
  localparam int unsigned IDX_W = 5;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick32.sv
// Combinational rotating-priority picker: first set bit of mask_i searching
// upward from start_i and wrapping from 31 back to 0.
module rr_pick32
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] mask_i,
  input  idx_t            start_i,
  output idx_t            idx_o,
  output logic            found_o
);

  idx_t cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites last.
  always_comb begin
    idx_o   = start_i;
    found_o = 1'b0;
    cand    = start_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = start_i + idx_t'(k);
      if (mask_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter driving the select of a shared 32:1 mux, with an
// optional hold-time limit that hands the resource to a waiting requester.
module rr_arbiter32
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            lock,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output idx_t            sel,
  output logic            preempt
);

  localparam logic [NREQ-1:0]  One       = {{(NREQ - 1){1'b0}}, 1'b1};
  localparam bit               PreemptEn = (MAX_HOLD != 0);
  // Saturation value of the hold counter; zero when preemption is disabled.
  localparam logic [CNT_W-1:0] HoldLast  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  idx_t             sel_q, sel_d;
  idx_t             ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic [NREQ-1:0]  others;
  logic [NREQ-1:0]  pick_mask;
  idx_t             pick_start;
  idx_t             win_idx;
  logic             win_found;

  assign others = req & ~(One << sel_q);

  // One picker serves both IDLE arbitration and GRANT handover.
  always_comb begin
    if (state_q == GRANT) begin
      pick_mask  = others;
      pick_start = sel_q + idx_t'(1);
    end else begin
      pick_mask  = req;
      pick_start = ptr_q;
    end
  end

  rr_pick32 u_pick (
    .mask_i  (pick_mask),
    .start_i (pick_start),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  // Next-state logic: release first, then hold-limit preemption, then hold.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          sel_d   = win_idx;
          gnt_d   = One << win_idx;
          ptr_d   = win_idx + idx_t'(1);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (win_found) begin
            sel_d  = win_idx;
            gnt_d  = One << win_idx;
            ptr_d  = win_idx + idx_t'(1);
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (PreemptEn && !lock && (hold_q == HoldLast) && win_found) begin
          sel_d     = win_idx;
          gnt_d     = One << win_idx;
          ptr_d     = win_idx + idx_t'(1);
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);
  assign sel       = sel_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32 with a hold limit of 4 cycles.
module tb_rr_arbiter32;
  import arb_pkg::*;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic            lock;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  idx_t            sel;
  logic            preempt;

  int checks = 0;
  int errors = 0;

  rr_arbiter32 #(
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel       (sel),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot against expected owner / valid / preempt.
  task automatic chk_all(input string tag, input logic [31:0] exp_gnt, input logic exp_v,
                         input logic [4:0] exp_sel, input logic exp_pre);
    chk({tag, ".gnt"}, gnt, exp_gnt);
    chk({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, exp_v});
    chk({tag, ".sel"}, {27'd0, sel}, {27'd0, exp_sel});
    chk({tag, ".preempt"}, {31'd0, preempt}, {31'd0, exp_pre});
  endtask

  // Structural invariant sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv.gnt_vs_sel", gnt, gnt_valid ? (32'd1 << sel) : 32'd0);
    end
  end

  initial begin
    logic [31:0] order [5];
    order = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    rst  = 1'b1;
    req  = '0;
    lock = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk_all("reset", 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_all("idle_hold", 32'h0, 1'b0, 5'd0, 1'b0);

    // Single request and release; sel is kept when going idle.
    req = 32'h0000_0010;
    tick();
    chk_all("single.grant", 32'h0000_0010, 1'b1, 5'd4, 1'b0);
    req = '0;
    tick();
    chk_all("single.release", 32'h0, 1'b0, 5'd4, 1'b0);

    // Asynchronous reset in the middle of a grant.
    req = 32'h0000_0010;
    tick();
    chk_all("async.pre", 32'h0000_0010, 1'b1, 5'd4, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async.reset", 32'h0, 1'b0, 5'd0, 1'b0);
    req = '0;
    #1 rst = 1'b0;

    // Wrap: grant 30 moves ptr to 31, then 31 wins over 0, then direct handover to 0.
    req = 32'h4000_0000;
    tick();
    chk_all("wrap.g30", 32'h4000_0000, 1'b1, 5'd30, 1'b0);
    req = '0;
    tick();
    req = 32'h8000_0001;
    tick();
    chk_all("wrap.g31", 32'h8000_0000, 1'b1, 5'd31, 1'b0);
    req = 32'h0000_0001;
    tick();
    chk_all("wrap.g0", 32'h0000_0001, 1'b1, 5'd0, 1'b0);
    req = '0;
    tick();
    chk_all("wrap.idle", 32'h0, 1'b0, 5'd0, 1'b0);

    // Back-to-back fairness from ptr 0; each owner drops after one cycle.
    rst = 1'b1;
    #2 rst = 1'b0;
    req = 32'h0000_000F;
    tick();
    chk_all("rr.first", 32'h1, 1'b1, 5'd0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      req = 32'h0000_000F & ~(32'd1 << order[k-1]);
      tick();
      chk_all($sformatf("rr.step%0d", k), 32'd1 << order[k], 1'b1, order[k][4:0], 1'b0);
    end
    req = '0;
    tick();
    chk_all("rr.idle", 32'h0, 1'b0, 5'd0, 1'b0);

    // Preemption after 4 cycles of ownership; preempted owner re-enters.
    req = 32'h0000_0004;
    tick();
    chk_all("pre.g2", 32'h4, 1'b1, 5'd2, 1'b0);
    req = 32'h0000_0024;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("pre.hold%0d", k), 32'h4, 1'b1, 5'd2, 1'b0);
    end
    tick();
    chk_all("pre.to5", 32'h20, 1'b1, 5'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("pre.own5_%0d", k), 32'h20, 1'b1, 5'd5, 1'b0);
    end
    tick();
    chk_all("pre.back2", 32'h4, 1'b1, 5'd2, 1'b1);
    req = '0;
    tick();
    chk_all("pre.idle", 32'h0, 1'b0, 5'd2, 1'b0);

    // Lock suppresses preemption until the owner drops.
    lock = 1'b1;
    req  = 32'h0000_0004;
    tick();
    chk_all("lock.g2", 32'h4, 1'b1, 5'd2, 1'b0);
    req = 32'h0000_0024;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all($sformatf("lock.hold%0d", k), 32'h4, 1'b1, 5'd2, 1'b0);
    end
    req = 32'h0000_0020;
    tick();
    chk_all("lock.release", 32'h20, 1'b1, 5'd5, 1'b0);
    lock = 1'b0;
    req  = '0;
    tick();
    chk_all("lock.idle", 32'h0, 1'b0, 5'd5, 1'b0);

    // Lone owner keeps grant past the limit; a newcomer preempts at once.
    req = 32'h0000_0080;
    tick();
    chk_all("lone.g7", 32'h80, 1'b1, 5'd7, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all($sformatf("lone.hold%0d", k), 32'h80, 1'b1, 5'd7, 1'b0);
    end
    req = 32'h0000_0280;
    tick();
    chk_all("lone.to9", 32'h200, 1'b1, 5'd9, 1'b1);
    tick();
    chk_all("lone.own9", 32'h200, 1'b1, 5'd9, 1'b0);
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
